// File: rtl/led_switch_pkg.sv
// Shared constants for the LED/switch user-logic stage: control bit positions,
// register offsets and the blink counter width.
package led_switch_pkg;

    localparam int unsigned CTRL_LED_EN   = 0;
    localparam int unsigned CTRL_IRQ_EN   = 1;
    localparam int unsigned CTRL_BLINK_EN = 2;

    localparam logic [3:0] REG_LED_DATA  = 4'h0;
    localparam logic [3:0] REG_CTRL      = 4'h4;
    localparam logic [3:0] REG_BLINK_PER = 4'h8;
    localparam logic [3:0] REG_EVENT     = 4'hC;

    localparam int unsigned BLINK_CNT_W = 32;

endpackage

// File: rtl/sw_debounce.sv
// Single switch channel: two-flop synchroniser, debounce counter and stable level.
// sw_change_o is high in the cycle whose rising edge updates the stable level.
module sw_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic sw_raw_i,
    output logic sw_state_o,
    output logic sw_change_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_change;

    assign w_diff   = r_sync2 ^ r_stable;
    assign w_change = w_diff && (r_cnt == CNT_MAX);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= sw_raw_i;
            r_sync2 <= r_sync1;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_change) begin
                r_cnt    <= '0;
                r_stable <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign sw_state_o  = r_stable;
    assign sw_change_o = w_change;

endmodule

// File: rtl/led_switch_core.sv
// LED/switch user logic: LED drive with optional blink, per-switch debounce,
// sticky W1C change events and a level interrupt.
module led_switch_core
    import led_switch_pkg::*;
#(
    parameter int unsigned NUM_LEDS           = 8,
    parameter int unsigned NUM_SW             = 8,
    parameter int unsigned DEBOUNCE_CYCLES    = 1000,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_LEDS-1:0]           led_data_i,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_i,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] blink_period_i,
    input  logic                          evt_clr_i,
    input  logic [NUM_SW-1:0]             evt_clr_mask_i,
    input  logic [NUM_SW-1:0]             sw_raw_i,
    output logic [NUM_SW-1:0]             sw_state_o,
    output logic [NUM_SW-1:0]             sw_event_o,
    output logic                          irq_o,
    output logic [NUM_LEDS-1:0]           led_o
);

    logic [NUM_SW-1:0]      w_change;
    logic [NUM_SW-1:0]      w_clr;
    logic [NUM_SW-1:0]      r_event;
    logic                   r_irq;
    logic [NUM_LEDS-1:0]    r_led;
    logic [BLINK_CNT_W-1:0] r_blink_cnt;
    logic [BLINK_CNT_W-1:0] w_period;
    logic                   r_phase;
    logic                   r_phase_valid;
    logic                   w_blink_active;
    logic                   w_ctrl_unused;

    assign w_ctrl_unused = ^ctrl_i;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_sw_debounce (
            .ACLK       (ACLK),
            .ARESETN    (ARESETN),
            .sw_raw_i   (sw_raw_i[g]),
            .sw_state_o (sw_state_o[g]),
            .sw_change_o(w_change[g])
        );
    end

    // Set wins over a simultaneous clear because the set term is OR-ed last.
    assign w_clr = evt_clr_i ? evt_clr_mask_i : '0;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_event <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_event <= (r_event & ~w_clr) | w_change;
            r_irq   <= ctrl_i[CTRL_IRQ_EN] & (|r_event);
        end
    end

    assign w_period       = blink_period_i[BLINK_CNT_W-1:0];
    assign w_blink_active = ctrl_i[CTRL_BLINK_EN] && (w_period != '0);

    // r_phase_valid forces the phase to 1 on the first clock after reset release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_blink_cnt   <= '0;
            r_phase       <= 1'b0;
            r_phase_valid <= 1'b0;
        end else begin
            r_phase_valid <= 1'b1;
            if (!r_phase_valid || !w_blink_active) begin
                r_blink_cnt <= '0;
                r_phase     <= 1'b1;
            end else if (r_blink_cnt == (w_period - 32'd1)) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_led <= '0;
        end else begin
            r_led <= ctrl_i[CTRL_LED_EN] ? (led_data_i & {NUM_LEDS{r_phase}}) : '0;
        end
    end

    assign sw_event_o = r_event;
    assign irq_o      = r_irq;
    assign led_o      = r_led;

endmodule

// File: tb/tb_led_switch_core.sv
// Directed bench for led_switch_core with DEBOUNCE_CYCLES = 4 and 8 LEDs/switches.
module tb_led_switch_core;

    logic        ACLK;
    logic        ARESETN;
    logic [7:0]  led_data_i;
    logic [31:0] ctrl_i;
    logic [31:0] blink_period_i;
    logic        evt_clr_i;
    logic [7:0]  evt_clr_mask_i;
    logic [7:0]  sw_raw_i;
    logic [7:0]  sw_state_o;
    logic [7:0]  sw_event_o;
    logic        irq_o;
    logic [7:0]  led_o;

    int n_cmp = 0;
    int n_err = 0;

    led_switch_core #(
        .NUM_LEDS          (8),
        .NUM_SW            (8),
        .DEBOUNCE_CYCLES   (4),
        .C_S_AXI_DATA_WIDTH(32)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .led_data_i    (led_data_i),
        .ctrl_i        (ctrl_i),
        .blink_period_i(blink_period_i),
        .evt_clr_i     (evt_clr_i),
        .evt_clr_mask_i(evt_clr_mask_i),
        .sw_raw_i      (sw_raw_i),
        .sw_state_o    (sw_state_o),
        .sw_event_o    (sw_event_o),
        .irq_o         (irq_o),
        .led_o         (led_o)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    initial begin
        ARESETN        = 1'b0;
        led_data_i     = 8'hA5;
        ctrl_i         = 32'h1;
        blink_period_i = 32'd0;
        evt_clr_i      = 1'b0;
        evt_clr_mask_i = 8'h00;
        sw_raw_i       = 8'h00;

        tick(3);
        chk("rst_led", 32'(led_o), 32'h00);
        chk("rst_state", 32'(sw_state_o), 32'h00);
        chk("rst_event", 32'(sw_event_o), 32'h00);
        chk("rst_irq", 32'(irq_o), 32'h0);

        ARESETN = 1'b1;
        tick(2);
        chk("led_after_release", 32'(led_o), 32'hA5);
        chk("state_after_release", 32'(sw_state_o), 32'h00);
        chk("irq_after_release", 32'(irq_o), 32'h0);

        // Clean rise on switch 0: stable level updates on the 6th edge.
        sw_raw_i = 8'h01;
        tick(5);
        chk("sw0_before_6", 32'(sw_state_o), 32'h00);
        chk("evt0_before_6", 32'(sw_event_o), 32'h00);
        tick(1);
        chk("sw0_at_6", 32'(sw_state_o), 32'h01);
        chk("evt0_at_6", 32'(sw_event_o), 32'h01);
        chk("irq_masked_a", 32'(irq_o), 32'h0);
        tick(1);
        chk("irq_masked_b", 32'(irq_o), 32'h0);
        ctrl_i = 32'h3;
        tick(1);
        chk("irq_enabled", 32'(irq_o), 32'h1);
        chk("led_with_irq_en", 32'(led_o), 32'hA5);

        // 3-cycle glitch on switch 3 must be rejected.
        sw_raw_i = 8'h09;
        tick(3);
        sw_raw_i = 8'h01;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("glitch_state", 32'(sw_state_o), 32'h01);
            chk("glitch_event", 32'(sw_event_o), 32'h01);
        end

        sw_raw_i = 8'h09;
        tick(6);
        chk("sw3_state", 32'(sw_state_o), 32'h09);
        chk("sw3_event", 32'(sw_event_o), 32'h09);
        chk("sw3_irq", 32'(irq_o), 32'h1);

        evt_clr_i      = 1'b1;
        evt_clr_mask_i = 8'h01;
        tick(1);
        evt_clr_i = 1'b0;
        chk("clr_bit0", 32'(sw_event_o), 32'h08);
        tick(1);
        chk("irq_after_clr0", 32'(irq_o), 32'h1);

        evt_clr_mask_i = 8'hFF;
        tick(1);
        chk("mask_ignored", 32'(sw_event_o), 32'h08);

        // Clear of bit 3 collides with its re-set on the falling edge.
        sw_raw_i = 8'h01;
        tick(5);
        chk("sw3_fall_pending", 32'(sw_state_o), 32'h09);
        evt_clr_i      = 1'b1;
        evt_clr_mask_i = 8'h08;
        tick(1);
        evt_clr_i = 1'b0;
        chk("sw3_fall_state", 32'(sw_state_o), 32'h01);
        chk("set_wins", 32'(sw_event_o), 32'h08);
        tick(1);
        chk("set_wins_hold", 32'(sw_event_o), 32'h08);

        // Blink with half-period 3: three cycles on, three off.
        ctrl_i         = 32'h5;
        blink_period_i = 32'd3;
        led_data_i     = 8'hFF;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            chk("blink_led", 32'(led_o), (((k - 1) / 3) % 2 == 0) ? 32'hFF : 32'h00);
        end
        chk("irq_disabled", 32'(irq_o), 32'h0);

        blink_period_i = 32'd0;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            chk("period0_steady", 32'(led_o), 32'hFF);
            tick(1);
        end

        // Asynchronous reset in the middle of a debounce and a blink.
        ctrl_i         = 32'h7;
        blink_period_i = 32'd3;
        sw_raw_i       = 8'h03;
        tick(4);
        chk("pre_rst_state", 32'(sw_state_o), 32'h01);
        chk("pre_rst_irq", 32'(irq_o), 32'h1);
        ARESETN = 1'b0;
        #1;
        chk("async_rst_led", 32'(led_o), 32'h00);
        chk("async_rst_state", 32'(sw_state_o), 32'h00);
        chk("async_rst_event", 32'(sw_event_o), 32'h00);
        chk("async_rst_irq", 32'(irq_o), 32'h0);
        tick(2);
        ARESETN = 1'b1;
        tick(5);
        chk("rerun_before_6", 32'(sw_state_o), 32'h00);
        tick(1);
        chk("rerun_at_6", 32'(sw_state_o), 32'h03);
        chk("rerun_event", 32'(sw_event_o), 32'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
